// File: rtl/balance_crossfeed_ramp.sv
// balance_crossfeed_ramp: stereo balance plus delayed crossfeed with ramped coefficients, two-stage pipeline.
module balance_crossfeed_ramp #(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 16,
    parameter int RAMP_STEP = 64,
    parameter int XF_DELAY  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_l,
    input  logic [DATA_W-1:0] s_r,
    input  logic [COEF_W-1:0] balance,
    input  logic [COEF_W-1:0] crossfeed,
    input  logic              bypass,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_l,
    output logic [DATA_W-1:0] m_r,
    output logic              clip_l,
    output logic              clip_r,
    output logic              ramp_busy
);
    localparam int PW = DATA_W + COEF_W;
    localparam int SW = PW + 1;
    localparam int PTR_W = XF_DELAY > 1 ? $clog2(XF_DELAY) : 1;
    localparam logic signed [COEF_W-1:0] ONE = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [COEF_W-1:0] MIN_C = {1'b1, {(COEF_W-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] STEP_C = COEF_W'(RAMP_STEP);
    localparam logic signed [COEF_W:0] STEP_D = (COEF_W+1)'(RAMP_STEP);
    localparam logic signed [SW-1:0] MAX_S = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic en, acc, v1, byp1;
    logic signed [COEF_W-1:0] b, gl_tgt, gr_tgt, c_tgt, gl_cur, gr_cur, c_cur;
    logic signed [DATA_W-1:0] ld, rd;
    logic signed [PW-1:0] pa_l, pa_r, pb_l, pb_r;
    logic [DATA_W-1:0] raw_l, raw_r;

    function automatic logic signed [COEF_W-1:0] ramp(input logic signed [COEF_W-1:0] cur, tgt);
        logic signed [COEF_W:0] d;
        d = (COEF_W+1)'(tgt) - (COEF_W+1)'(cur);
        return (d > STEP_D) ? cur + STEP_C : (d < -STEP_D) ? cur - STEP_C : tgt;
    endfunction

    // Returns {clip, sample}: floor-scaled sum saturated to the sample range.
    function automatic logic [DATA_W:0] sat(input logic signed [PW-1:0] a, c);
        logic signed [SW-1:0] s;
        s = SW'(a) + SW'(c);
        s = s >>> (COEF_W-1);
        return (s > MAX_S) ? {1'b1, MAX_S[DATA_W-1:0]} :
               (s < MIN_S) ? {1'b1, MIN_S[DATA_W-1:0]} : {1'b0, s[DATA_W-1:0]};
    endfunction

    assign en = !m_valid || m_ready;
    assign s_ready = en;
    assign acc = s_valid && en;
    assign b = ($signed(balance) == MIN_C) ? -ONE : $signed(balance);
    assign gl_tgt = b[COEF_W-1] ? ONE : ONE - b;
    assign gr_tgt = b[COEF_W-1] ? ONE + b : ONE;
    assign c_tgt = crossfeed[COEF_W-1] ? ONE : $signed(crossfeed);
    assign ramp_busy = (gl_cur != gl_tgt) || (gr_cur != gr_tgt) || (c_cur != c_tgt);

    generate
        if (XF_DELAY == 0) begin : g_nodl
            assign ld = $signed(s_l);
            assign rd = $signed(s_r);
        end else begin : g_dl
            logic signed [DATA_W-1:0] dl_l [2**PTR_W];
            logic signed [DATA_W-1:0] dl_r [2**PTR_W];
            logic [PTR_W-1:0] wp;
            // The slot about to be overwritten holds the sample from XF_DELAY accepts ago.
            assign ld = dl_l[wp];
            assign rd = dl_r[wp];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wp <= '0;
                    for (int i = 0; i < 2**PTR_W; i++) begin
                        dl_l[i] <= '0;
                        dl_r[i] <= '0;
                    end
                end else if (acc) begin
                    dl_l[wp] <= $signed(s_l);
                    dl_r[wp] <= $signed(s_r);
                    wp <= (wp == PTR_W'(XF_DELAY-1)) ? '0 : wp + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gl_cur <= ONE;
            gr_cur <= ONE;
            c_cur <= '0;
            v1 <= 1'b0;
            byp1 <= 1'b0;
            pa_l <= '0;
            pa_r <= '0;
            pb_l <= '0;
            pb_r <= '0;
            raw_l <= '0;
            raw_r <= '0;
        end else begin
            if (en)
                v1 <= s_valid;
            if (acc) begin
                pa_l <= gl_cur * $signed(s_l);
                pa_r <= gr_cur * $signed(s_r);
                pb_l <= c_cur * rd;
                pb_r <= c_cur * ld;
                byp1 <= bypass;
                raw_l <= s_l;
                raw_r <= s_r;
                gl_cur <= ramp(gl_cur, gl_tgt);
                gr_cur <= ramp(gr_cur, gr_tgt);
                c_cur <= ramp(c_cur, c_tgt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_l <= '0;
            m_r <= '0;
            clip_l <= 1'b0;
            clip_r <= 1'b0;
        end else if (en) begin
            m_valid <= v1;
            if (v1) begin
                {clip_l, m_l} <= byp1 ? {1'b0, raw_l} : sat(pa_l, pb_l);
                {clip_r, m_r} <= byp1 ? {1'b0, raw_r} : sat(pa_r, pb_r);
            end
        end
    end
endmodule

// File: doc/balance_crossfeed_ramp.md
Name: balance_crossfeed_ramp

Overview:
Parametrised stereo balance and crossfeed stage for the DSP chain, placed after volume and before the output formatter.
- Scales each channel by a balance gain and adds a crossfeed portion of the opposite channel, delayed by a fixed number of samples (interaural delay).
- All three coefficients move linearly toward their targets (zipper-free).
- Two-stage pipeline with ready/valid handshake and output saturation.

Parameters:
- DATA_W, 24, sample width (signed two's complement).
- COEF_W, 16, coefficient width, Q1.(COEF_W-1); ONE = 2^(COEF_W-1)-1.
- RAMP_STEP, 64, maximum coefficient change per accepted sample (LSBs).
- XF_DELAY, 4, crossfeed delay in accepted samples. Legal range 0..15; 0 means the current opposite sample.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- s_valid, in, 1, input sample pair valid.
- s_ready, out, 1, block accepts the pair this cycle.
- s_l / s_r, in, DATA_W, signed input samples.
- balance, in, COEF_W, signed target; <0 attenuates R, >0 attenuates L.
- crossfeed, in, COEF_W, unsigned target crossfeed amount.
- bypass, in, 1, sampled at accept; the pair passes through unmodified.
- m_valid, out, 1, output pair valid.
- m_ready, in, 1, downstream accepts.
- m_l / m_r, out, DATA_W, signed output samples.
- clip_l / clip_r, out, 1, saturation occurred on the current output pair (qualified by m_valid).
- ramp_busy, out, 1, any current coefficient differs from its target.

Behaviour:
- Reset (async):
  - m_valid=0, m_l=m_r=0, clip_l=clip_r=0.
  - gL_cur=gR_cur=ONE, c_cur=0, all delay-line entries 0.
  - ramp_busy reflects targets vs reset values from the first cycle after release.
  - Reset mid-operation discards all in-flight samples; no partial output is produced.
- Targets (combinational):
  - b = balance, with -2^(COEF_W-1) clamped to -ONE.
  - gL_tgt = ONE - max(b,0); gR_tgt = ONE - max(-b,0).
  - c_tgt = min(crossfeed, ONE).
- Handshake:
  - en = !m_valid || m_ready; s_ready = en (combinational from m_ready).
  - Accept = s_valid && s_ready.
  - While m_valid && !m_ready: m_l, m_r, clip_l, clip_r are held stable and both stages hold.
- Latency and throughput:
  - Accept at cycle t gives m_valid at t+2 if en stays high.
  - Throughput is one pair per cycle.
- Stage 1 (on accept):
  - Registers gL_cur*L, gR_cur*R, c_cur*Rd, c_cur*Ld, bypass, raw L/R.
  - Rd/Ld are the opposite-channel samples from XF_DELAY accepts earlier.
  - Delay line and ramps advance only on accept, never on idle or stall cycles.
- Coefficient ramp:
  - A sample always uses the coefficients present before the update in its own accept cycle.
  - Then each cur moves toward its tgt by min(RAMP_STEP, |tgt-cur|).
  - Target changes mid-ramp redirect from the current value.
  - Ramps continue while bypass=1.
- Stage 2:
  - sum = prodA + prodB at width DATA_W+COEF_W+1, then arithmetic shift right by COEF_W-1 (floor).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; clip_x=1 when saturation occurred for that pair.
  - With bypass: output = raw input, clip=0.
- Delay line: per-channel circular buffer of depth XF_DELAY, write pointer wraps at XF_DELAY-1. Delay-line writes still occur during bypass.

Test Plan:
- Reset release, balance=0, crossfeed=0:
  - Outputs 0, m_valid=0, ramp_busy=0.
  - L=0x100000, R=0 → m_l=0x0FFFE0, m_r=0 two cycles after accept.
- crossfeed=16384 from reset, continuous valid, RAMP_STEP=64:
  - ramp_busy stays high for exactly 256 accepts, low after the 256th.
  - Accept n (0-based) uses c=64n.
- After ramp to c=16384, XF_DELAY=4, L impulse 0x100000 at accept k, R=0 throughout:
  - m_r=0x080000 at output k+4; m_r=0 at all other outputs.
- balance=-32768 (clamped):
  - gR ramps to 0 and gL stays ONE.
  - After settle, R=0x400000 → m_r=0.
- Saturation, gains=ONE, c=ONE, XF_DELAY=0, L=R=0x7FFFFF:
  - m_l=m_r=0x7FFFFF with clip_l=clip_r=1.
  - With L=R=0x800000: outputs 0x800000, clips=1.
- Stall:
  - m_ready low for 5 cycles with s_valid high: s_ready=0, outputs held, coefficients and delay line frozen.
  - On release, the sequence continues with no loss or duplication.
  - Assert rst_n low mid-stream: m_valid drops immediately and the first post-reset output equals the reset-state computation.
